circle_tx: RTL
==============

CIRCLE_TX -- requirements
Module: circle_tx

Interface
REQ-001 Parameter N_BEATS, 8, number of 5-bit operands sent per job and number of 6-bit results expected back.
REQ-002 Parameter TIMEOUT, 1000, idle cycles allowed in WAIT/RECV without out_valid before abort.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ld_valid  input  1  host offers operand on ld_data.
REQ-006 ld_data  input  5  operand to buffer.
REQ-007 ld_ready  output  1  operand accepted this cycle when ld_valid&ld_ready.
REQ-008 start  input  1  one-cycle request to send buffered job.
REQ-009 c1_cfg / c2_cfg  input  3 each  circle selections, sampled on accepted start.
REQ-010 in_valid  output  1  operand beat to Circle.
REQ-011 in  output  5  operand value.
REQ-012 circle1 / circle2  output  3 each  circle selections, valid on first beat only.
REQ-013 out_valid  input  1  result beat from Circle.
REQ-014 out  input  6  result value.
REQ-015 res_valid  output  1  forwarded result beat to host.
REQ-016 res_data  output  6  forwarded result value.
REQ-017 busy  output  1  high in SEND, WAIT, RECV, DONE.
REQ-018 done  output  1  one-cycle pulse, job completed.
REQ-019 err  output  1  one-cycle pulse, job aborted.

Function
REQ-020 States IDLE, SEND, WAIT, RECV, DONE; 8-entry operand buffer, write count cnt (0..N_BEATS).
REQ-021 IDLE: ld_ready = (cnt < N_BEATS); accepted operand written at buf[cnt], cnt+1; ld_ready=0 in all other states.
REQ-022 IDLE: start with cnt==N_BEATS accepted -> latch c1_cfg/c2_cfg, go SEND; start with cnt<N_BEATS ignored, no err.
REQ-023 ld_valid and start in same cycle with cnt==N_BEATS-1: operand accepted, start ignored.
REQ-024 SEND: N_BEATS consecutive cycles, in_valid=1, in=buf[i], i=0..N_BEATS-1; first beat in the cycle after accepted start.
REQ-025 circle1/circle2 = latched values when i==0, else 0; in=0 whenever in_valid=0.
REQ-026 After last beat -> WAIT; in_valid=0 from next cycle.
REQ-027 out_valid during IDLE or SEND ignored.
REQ-028 WAIT/RECV: each out_valid beat -> res_valid=1, res_data=out exactly one cycle later (registered); first beat moves WAIT->RECV; gaps between beats allowed.
REQ-029 After N_BEATS-th result beat -> DONE; DONE lasts one cycle, done=1, cnt cleared to 0, then IDLE.
REQ-030 res_valid=0, res_data=0 when no beat forwarded.

Reset
REQ-031 rst asserted -> immediately (no clock): state IDLE, cnt=0, beat/result counters 0, latched circles 0, all outputs 0 except ld_ready which becomes 1 after rst deasserts.
REQ-032 rst mid-job discards buffer and partial results; no done/err pulse generated.

Configuration
REQ-033 Macro CIRCLE_TX_TIMEOUT_EN: defined -> idle counter in WAIT/RECV, cleared on each out_valid; reaching TIMEOUT -> err=1 one cycle, cnt=0, state IDLE, no further res_valid.
REQ-034 Macro undefined -> no counter, err tied 0, block waits indefinitely in WAIT/RECV.

Verification
REQ-035 Load 1..8, c1=3, c2=5, start -> in_valid 8 cycles, in=1..8, circle1=3/circle2=5 on beat 1 only, busy=1.
REQ-036 Load 7 operands, start -> ignored, no in_valid; 8th load with start same cycle -> accepted, start ignored; next start sends.
REQ-037 Responder returns 8 results 0x00..0x3F spaced by gaps -> res_valid/res_data one cycle after each out_valid, done pulse after 8th, busy falls.
REQ-038 CIRCLE_TX_TIMEOUT_EN, TIMEOUT=1000, responder returns 3 beats then stops -> err after 1000 idle cycles, back to IDLE, ld_ready=1.
REQ-039 rst pulse during SEND beat 4 -> in_valid=0 asynchronously, cnt=0, no done/err; fresh job afterwards runs normally.
REQ-040 out_valid pulses during IDLE and SEND -> no res_valid, job result count unaffected.

Source files
------------

// File: rtl/circle_tx.sv
// Host-side transmitter for the Circle engine: buffers N_BEATS operands, streams them out,
// then forwards N_BEATS results back. Optional watchdog abort via CIRCLE_TX_TIMEOUT_EN.
module circle_tx #(
    parameter int N_BEATS = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_valid,
    input  logic [4:0] ld_data,
    output logic       ld_ready,
    input  logic       start,
    input  logic [2:0] c1_cfg,
    input  logic [2:0] c2_cfg,
    output logic       in_valid,
    output logic [4:0] in,
    output logic [2:0] circle1,
    output logic [2:0] circle2,
    input  logic       out_valid,
    input  logic [5:0] out,
    output logic       res_valid,
    output logic [5:0] res_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(N_BEATS + 1);
    localparam int IW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CW-1:0] N_CNT  = CW'(N_BEATS);
    localparam logic [CW-1:0] N_LAST = CW'(N_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [CW-1:0]   idx_r, idx_s;
    logic [CW-1:0]   rcnt_r, rcnt_s;
    logic [4:0]      op_mem_r [N_BEATS];
    logic            wr_en_s;
    logic            in_valid_r, in_valid_s;
    logic [4:0]      in_r, in_s;
    logic [2:0]      circle1_r, circle1_s;
    logic [2:0]      circle2_r, circle2_s;
    logic            res_valid_r, res_valid_s;
    logic [5:0]      res_data_r, res_data_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            ld_ready_r, ld_ready_s;

`ifdef CIRCLE_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]   tcnt_r, tcnt_s;
    logic            err_r, err_s;
`endif

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        rcnt_s      = rcnt_r;
        wr_en_s     = 1'b0;
        in_valid_s  = 1'b0;
        in_s        = 5'd0;
        circle1_s   = 3'd0;
        circle2_s   = 3'd0;
        res_valid_s = 1'b0;
        res_data_s  = 6'd0;
        done_s      = 1'b0;
`ifdef CIRCLE_TX_TIMEOUT_EN
        tcnt_s      = tcnt_r;
        err_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                // a load wins over start, so a start alongside the last load is dropped
                if (ld_valid && (cnt_r < N_CNT)) begin
                    wr_en_s = 1'b1;
                    cnt_s   = cnt_r + 1'b1;
                end else if (start && (cnt_r == N_CNT)) begin
                    state_s    = ST_SEND;
                    in_valid_s = 1'b1;
                    in_s       = op_mem_r[0];
                    circle1_s  = c1_cfg;
                    circle2_s  = c2_cfg;
                    idx_s      = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (idx_r < N_CNT) begin
                    in_valid_s = 1'b1;
                    in_s       = op_mem_r[idx_r[IW-1:0]];
                    idx_s      = idx_r + 1'b1;
                end else begin
                    state_s = ST_WAIT;
                    idx_s   = {CW{1'b0}};
                    rcnt_s  = {CW{1'b0}};
`ifdef CIRCLE_TX_TIMEOUT_EN
                    tcnt_s  = {TW{1'b0}};
`endif
                end
            end
            ST_WAIT, ST_RECV: begin
                if (out_valid) begin
                    res_valid_s = 1'b1;
                    res_data_s  = out;
                    rcnt_s      = rcnt_r + 1'b1;
`ifdef CIRCLE_TX_TIMEOUT_EN
                    tcnt_s      = {TW{1'b0}};
`endif
                    if (rcnt_r == N_LAST) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RECV;
                    end
                end else begin
`ifdef CIRCLE_TX_TIMEOUT_EN
                    if (tcnt_r == T_LAST) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                        cnt_s   = {CW{1'b0}};
                        rcnt_s  = {CW{1'b0}};
                        tcnt_s  = {TW{1'b0}};
                    end else begin
                        tcnt_s  = tcnt_r + 1'b1;
                    end
`else
                    state_s = state_r;
`endif
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
                rcnt_s  = {CW{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
        busy_s     = (state_s != ST_IDLE);
        ld_ready_s = (state_s == ST_IDLE) && (cnt_s < N_CNT);
    end

    // State, counters, operand buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            idx_r       <= {CW{1'b0}};
            rcnt_r      <= {CW{1'b0}};
            op_mem_r    <= '{default: 5'd0};
            in_valid_r  <= 1'b0;
            in_r        <= 5'd0;
            circle1_r   <= 3'd0;
            circle2_r   <= 3'd0;
            res_valid_r <= 1'b0;
            res_data_r  <= 6'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ld_ready_r  <= 1'b0;
`ifdef CIRCLE_TX_TIMEOUT_EN
            tcnt_r      <= {TW{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            rcnt_r      <= rcnt_s;
            if (wr_en_s) begin
                op_mem_r[cnt_r[IW-1:0]] <= ld_data;
            end
            in_valid_r  <= in_valid_s;
            in_r        <= in_s;
            circle1_r   <= circle1_s;
            circle2_r   <= circle2_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            ld_ready_r  <= ld_ready_s;
`ifdef CIRCLE_TX_TIMEOUT_EN
            tcnt_r      <= tcnt_s;
            err_r       <= err_s;
`endif
        end
    end

    assign ld_ready  = ld_ready_r;
    assign in_valid  = in_valid_r;
    assign in        = in_r;
    assign circle1   = circle1_r;
    assign circle2   = circle2_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign busy      = busy_r;
    assign done      = done_r;
`ifdef CIRCLE_TX_TIMEOUT_EN
    assign err       = err_r;
`else
    assign err       = 1'b0;
`endif

endmodule
